// File: rtl/qbus_dma_arbiter.sv
// Q-bus DMA ownership sequencer between NREQ local requesters and the VM1 DMR/DMGO/SACK pins.
// Optional rotating priority: define QBUS_DMA_ROUND_ROBIN_EN (fixed priority, index 0 highest, otherwise).
module qbus_dma_arbiter #(
    parameter int NREQ  = 2,
    parameter int TMO   = 64,
    parameter int IDX_W = 2
) (
    input  logic             CLK,
    input  logic             nRESET,
    input  logic [NREQ-1:0]  nREQ_DMR,
    input  logic [NREQ-1:0]  nREQ_SACK,
    output logic [NREQ-1:0]  nREQ_DMG,
    output logic             nCPU_DMR,
    input  logic             nCPU_DMGO,
    output logic             nCPU_SACK,
    output logic [IDX_W-1:0] OWNER,
    output logic             BUSY,
    output logic             TMO_ERR
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_REQ   = 3'd1,
        S_GRANT = 3'd2,
        S_OWN   = 3'd3,
        S_REL   = 3'd4
    } state_t;

    localparam logic [7:0] TMO_LAST = 8'(TMO - 1);

    state_t           r_state;
    state_t           w_state_next;
    logic [7:0]       r_cnt;
    logic [7:0]       w_cnt_next;

    logic             r_dmgo_s1;
    logic             r_dmgo_s2;
    logic [NREQ-1:0]  w_dmr_n;
    logic [NREQ-1:0]  w_sack_n;
    logic [NREQ-1:0]  w_req;
    logic [NREQ-1:0]  w_own_sel;
    logic             w_any_req;
    logic             w_sack_own;

    logic [IDX_W-1:0] w_start;
    logic [NREQ-1:0]  w_rot;
    logic [IDX_W-1:0] w_win_idx;

    logic [NREQ-1:0]  r_dmg_n;
    logic             r_cpu_dmr_n;
    logic             r_cpu_sack_n;
    logic [IDX_W-1:0] r_owner;
    logic             r_busy;
    logic             r_tmo_err;

    logic [NREQ-1:0]  w_dmg_next;
    logic             w_cpu_dmr_next;
    logic             w_cpu_sack_next;
    logic [IDX_W-1:0] w_owner_next;
    logic             w_busy_next;
    logic             w_tmo_err_next;

    // Per-requester synchronizers and grant decode
    genvar gi;
    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_req
            logic r_dmr_s1;
            logic r_dmr_s2;
            logic r_sack_s1;
            logic r_sack_s2;

            always_ff @(posedge CLK or negedge nRESET) begin
                if (!nRESET) begin
                    r_dmr_s1  <= 1'b1;
                    r_dmr_s2  <= 1'b1;
                    r_sack_s1 <= 1'b1;
                    r_sack_s2 <= 1'b1;
                end else begin
                    r_dmr_s1  <= nREQ_DMR[gi];
                    r_dmr_s2  <= r_dmr_s1;
                    r_sack_s1 <= nREQ_SACK[gi];
                    r_sack_s2 <= r_sack_s1;
                end
            end

            assign w_dmr_n[gi]    = r_dmr_s2;
            assign w_sack_n[gi]   = r_sack_s2;
            assign w_own_sel[gi]  = (r_owner == IDX_W'(gi));
            assign w_dmg_next[gi] = ~((w_state_next == S_GRANT) && (w_owner_next == IDX_W'(gi)));
        end
    endgenerate

    always_ff @(posedge CLK or negedge nRESET) begin
        if (!nRESET) begin
            r_dmgo_s1 <= 1'b1;
            r_dmgo_s2 <= 1'b1;
        end else begin
            r_dmgo_s1 <= nCPU_DMGO;
            r_dmgo_s2 <= r_dmgo_s1;
        end
    end

    assign w_req      = ~w_dmr_n;
    assign w_any_req  = |w_req;
    // Only the current owner's SACK is ever looked at; foreign SACKs are masked here.
    assign w_sack_own = |(w_own_sel & ~w_sack_n);

`ifdef QBUS_DMA_ROUND_ROBIN_EN
    logic [IDX_W-1:0] r_rr_ptr;

    // Search start moves past the owner only after a completed (SACKed) session.
    always_ff @(posedge CLK or negedge nRESET) begin
        if (!nRESET) begin
            r_rr_ptr <= '0;
        end else if ((r_state == S_GRANT) && (w_state_next == S_OWN)) begin
            r_rr_ptr <= IDX_W'((int'(r_owner) + 1) % NREQ);
        end
    end

    assign w_start = r_rr_ptr;
`else
    assign w_start = '0;
`endif

    // Rotate requests so the search start sits at bit 0, then pick the lowest set bit.
    always_comb begin : p_winner
        int v_off;
        v_off = 0;
        w_rot = NREQ'({w_req, w_req} >> w_start);
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (w_rot[i]) begin
                v_off = i;
            end
        end
        w_win_idx = IDX_W'((v_off + int'(w_start)) % NREQ);
    end

    // State register (outputs are registered alongside the state)
    always_ff @(posedge CLK or negedge nRESET) begin
        if (!nRESET) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_dmg_n      <= '1;
            r_cpu_dmr_n  <= 1'b1;
            r_cpu_sack_n <= 1'b1;
            r_owner      <= '0;
            r_busy       <= 1'b0;
            r_tmo_err    <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_cnt        <= w_cnt_next;
            r_dmg_n      <= w_dmg_next;
            r_cpu_dmr_n  <= w_cpu_dmr_next;
            r_cpu_sack_n <= w_cpu_sack_next;
            r_owner      <= w_owner_next;
            r_busy       <= w_busy_next;
            r_tmo_err    <= w_tmo_err_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        case (r_state)
            S_IDLE: begin
                if (w_any_req) begin
                    w_state_next = S_REQ;
                end
            end
            S_REQ: begin
                // A CPU request is never withdrawn; a grant with nobody left is absorbed.
                if (!r_dmgo_s2) begin
                    if (w_any_req) begin
                        w_state_next = S_GRANT;
                        w_cnt_next   = '0;
                    end else begin
                        w_state_next = S_REL;
                    end
                end
            end
            S_GRANT: begin
                if (w_sack_own) begin
                    w_state_next = S_OWN;
                end else if (r_cnt == TMO_LAST) begin
                    w_state_next = S_REL;
                end else begin
                    w_cnt_next = r_cnt + 8'd1;
                end
            end
            S_OWN: begin
                if (!w_sack_own) begin
                    w_state_next = S_REL;
                end
            end
            S_REL: begin
                if (r_dmgo_s2) begin
                    w_state_next = S_IDLE;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // Output logic: next values of the registered outputs
    always_comb begin
        w_owner_next = r_owner;
        if ((r_state == S_REQ) && (w_state_next == S_GRANT)) begin
            w_owner_next = w_win_idx;
        end
        w_cpu_dmr_next  = ~((w_state_next == S_REQ) || (w_state_next == S_GRANT));
        w_cpu_sack_next = (w_state_next != S_OWN);
        // BUSY survives into REL only when a grant was actually issued.
        w_busy_next     = (w_state_next == S_GRANT) || (w_state_next == S_OWN) ||
                          ((w_state_next == S_REL) && r_busy);
        w_tmo_err_next  = (r_state == S_GRANT) && (w_state_next == S_REL);
    end

    assign nREQ_DMG  = r_dmg_n;
    assign nCPU_DMR  = r_cpu_dmr_n;
    assign nCPU_SACK = r_cpu_sack_n;
    assign OWNER     = r_owner;
    assign BUSY      = r_busy;
    assign TMO_ERR   = r_tmo_err;

endmodule

// File: tb/tb_qbus_dma_arbiter.sv
// Bench for qbus_dma_arbiter: directed session table, withdrawn-request and reset-in-OWN
// sequences, then randomized sessions checked against a latency/priority reference model.
module tb_qbus_dma_arbiter;

    localparam int NREQ  = 2;
    localparam int TMO   = 16;
    localparam int IDX_W = 2;
    localparam int LAT   = 3;
`ifdef QBUS_DMA_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic             CLK = 1'b0;
    logic             nRESET;
    logic [NREQ-1:0]  nREQ_DMR;
    logic [NREQ-1:0]  nREQ_SACK;
    logic [NREQ-1:0]  nREQ_DMG;
    logic             nCPU_DMR;
    logic             nCPU_DMGO;
    logic             nCPU_SACK;
    logic [IDX_W-1:0] OWNER;
    logic             BUSY;
    logic             TMO_ERR;

    always #5 CLK = ~CLK;

    qbus_dma_arbiter #(.NREQ(NREQ), .TMO(TMO), .IDX_W(IDX_W)) dut (
        .CLK       (CLK),
        .nRESET    (nRESET),
        .nREQ_DMR  (nREQ_DMR),
        .nREQ_SACK (nREQ_SACK),
        .nREQ_DMG  (nREQ_DMG),
        .nCPU_DMR  (nCPU_DMR),
        .nCPU_DMGO (nCPU_DMGO),
        .nCPU_SACK (nCPU_SACK),
        .OWNER     (OWNER),
        .BUSY      (BUSY),
        .TMO_ERR   (TMO_ERR)
    );

    typedef struct {
        logic [NREQ-1:0] mask;      // requesters asserting DMR
        int              cpu_dly;   // cycles from nCPU_DMR low to DMGO low
        int              sack_dly;  // cycles from DMG seen to SACK (0 = never)
        int              hold;      // SACK hold cycles
        bit              fsack;     // foreign SACK pulse during GRANT
        int              own_fix;   // expected owner, fixed priority
        int              own_rr;    // expected owner, rotating priority
        int              dmg_len;   // cycles owner DMG low
        int              tmo;       // TMO_ERR high cycles
        int              sack_len;  // cycles nCPU_SACK low
    } vec_t;

    vec_t vecs[9];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   m_ptr    = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, required %0d", name, act, exp);
    endtask

    function automatic bit cond(input int sel);
        case (sel)
            0: return nCPU_DMR === 1'b0;
            1: return nREQ_DMG !== {NREQ{1'b1}};
            2: return nCPU_SACK === 1'b0;
            3: return BUSY === 1'b0;
            default: return 1'b0;
        endcase
    endfunction

    // Bounded wait; cyc = negedges waited, or -1 if the condition never appeared.
    task automatic wait_for(input int sel, output int cyc);
        cyc = 0;
        while (!cond(sel) && cyc < 40) begin
            @(negedge CLK);
            cyc++;
        end
        if (!cond(sel)) cyc = -1;
    endtask

    // Reference: priority search from the rotating start (0 in the fixed build).
    function automatic int model_winner(input logic [NREQ-1:0] mask, input int ptr);
        int start;
        start = RR ? ptr : 0;
        for (int k = 0; k < NREQ; k++) begin
            if (mask[(start + k) % NREQ]) return (start + k) % NREQ;
        end
        return -1;
    endfunction

    // Reference: SACK reaches the FSM LAT cycles after it is driven; it wins if that is
    // no later than the TMO-th grant cycle.
    function automatic vec_t model_session(input logic [NREQ-1:0] mask, input int c,
                                           input int d, input int h, input bit fs);
        vec_t v;
        bit   ok;
        ok = (d != 0) && (d + LAT <= TMO);
        v.mask = mask; v.cpu_dly = c; v.sack_dly = d; v.hold = h; v.fsack = fs;
        v.own_fix  = model_winner(mask, m_ptr);
        v.own_rr   = v.own_fix;
        v.dmg_len  = ok ? d + LAT : TMO;
        v.tmo      = ok ? 0 : 1;
        v.sack_len = ok ? h : 0;
        return v;
    endfunction

    task automatic run_session(input vec_t v, input string tag);
        int lat, own, other, win, nlow, idx;
        int dmg_cnt, oth_cnt, tmo_cnt, sack_cnt;
        bit sacking;
        own = RR ? v.own_rr : v.own_fix;
        other = (own == 0) ? 1 : 0;
        dmg_cnt = 0; oth_cnt = 0; tmo_cnt = 0; sack_cnt = 0; sacking = 1'b0;

        nREQ_DMR = ~v.mask;
        wait_for(0, lat);
        chk({tag, ".dmr_lat"}, lat, LAT);
        repeat (v.cpu_dly) @(negedge CLK);
        nCPU_DMGO = 1'b0;
        wait_for(1, lat);
        chk({tag, ".dmg_lat"}, lat, LAT);
        nlow = 0; idx = -1;
        for (int i = 0; i < NREQ; i++) begin
            if (nREQ_DMG[i] === 1'b0) begin
                nlow++;
                idx = i;
            end
        end
        chk({tag, ".grant_cnt"}, nlow, 1);
        chk({tag, ".grant_idx"}, idx, own);
        chk({tag, ".owner"}, int'(OWNER), own);
        chk({tag, ".busy"}, int'(BUSY), 1);
        nREQ_DMR = '1;

        win = ((v.sack_dly + v.hold > TMO) ? v.sack_dly + v.hold : TMO) + 6;
        for (int t = 0; t < win; t++) begin
            if (nREQ_DMG[own] === 1'b0) dmg_cnt++;
            for (int i = 0; i < NREQ; i++) begin
                if (i != own && nREQ_DMG[i] === 1'b0) oth_cnt++;
            end
            if (TMO_ERR === 1'b1) tmo_cnt++;
            if (nCPU_SACK === 1'b0) sack_cnt++;
            if (v.sack_dly != 0 && t == v.sack_dly && nREQ_DMG[own] === 1'b0) begin
                nREQ_SACK[own] = 1'b0;
                sacking = 1'b1;
            end
            if (sacking && t == v.sack_dly + v.hold) nREQ_SACK[own] = 1'b1;
            if (v.fsack && t == 1) nREQ_SACK[other] = 1'b0;
            if (v.fsack && t == 5) nREQ_SACK[other] = 1'b1;
            @(negedge CLK);
        end
        chk({tag, ".dmg_len"}, dmg_cnt, v.dmg_len);
        chk({tag, ".tmo_err"}, tmo_cnt, v.tmo);
        chk({tag, ".sack_len"}, sack_cnt, v.sack_len);
        chk({tag, ".other_dmg"}, oth_cnt, 0);
        chk({tag, ".dmr_end"}, int'(nCPU_DMR), 1);

        nREQ_SACK = '1;
        nCPU_DMGO = 1'b1;
        wait_for(3, lat);
        chk({tag, ".busy_lat"}, lat, LAT);
        if (RR && v.tmo == 0) m_ptr = (own + 1) % NREQ;
        $display("session %s: mask=%b owner=%0d dmg=%0d tmo=%0d sack=%0d", tag, v.mask, idx,
                 dmg_cnt, tmo_cnt, sack_cnt);
        repeat (3) @(negedge CLK);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int mism, dmg_low, busy_hi, tmo_hi, cyc, s;
        vec_t v;

        //         mask   c  d   h  fs own_fix own_rr dmg tmo sack
        vecs[0] = '{2'b11, 3, 2,  6, 1'b0, 0, 0,  5, 0,  6};
        vecs[1] = '{2'b11, 2, 5,  3, 1'b0, 0, 1,  8, 0,  3};
        vecs[2] = '{2'b01, 5, 4, 20, 1'b0, 0, 0,  7, 0, 20};
        vecs[3] = '{2'b10, 4, 0,  0, 1'b0, 1, 1, 16, 1,  0};
        vecs[4] = '{2'b11, 1, 3,  4, 1'b0, 0, 1,  6, 0,  4};
        vecs[5] = '{2'b11, 2, 13, 2, 1'b0, 0, 0, 16, 0,  2};
        vecs[6] = '{2'b01, 2, 14, 3, 1'b0, 0, 0, 16, 1,  0};
        vecs[7] = '{2'b01, 6, 6,  8, 1'b1, 0, 0,  9, 0,  8};
        vecs[8] = '{2'b10, 1, 1,  1, 1'b0, 1, 1,  4, 0,  1};

        nRESET = 1'b0; nREQ_DMR = '1; nREQ_SACK = '1; nCPU_DMGO = 1'b1;
        repeat (3) @(negedge CLK);
        chk("reset.dmg", int'(nREQ_DMG), (1 << NREQ) - 1);
        chk("reset.dmr", int'(nCPU_DMR), 1);
        chk("reset.sack", int'(nCPU_SACK), 1);
        chk("reset.owner", int'(OWNER), 0);
        chk("reset.busy", int'(BUSY), 0);
        chk("reset.tmo_err", int'(TMO_ERR), 0);
        nRESET = 1'b1;
        repeat (3) @(negedge CLK);

        for (int i = 0; i < 9; i++) run_session(vecs[i], $sformatf("vec%0d", i));

        // Withdrawn request: DMR pulse of 4 cycles, grant 10 cycles after nCPU_DMR.
        mism = 0; dmg_low = 0; busy_hi = 0; tmo_hi = 0;
        for (int t = 0; t < 32; t++) begin
            if (t == 0)  nREQ_DMR[0] = 1'b0;
            if (t == 4)  nREQ_DMR[0] = 1'b1;
            if (t == 13) nCPU_DMGO = 1'b0;
            if (t == 20) nCPU_DMGO = 1'b1;
            @(negedge CLK);
            s = t + 1;
            if (nCPU_DMR !== ((s >= 3 && s <= 15) ? 1'b0 : 1'b1)) mism++;
            if (nREQ_DMG !== {NREQ{1'b1}}) dmg_low++;
            if (BUSY !== 1'b0) busy_hi++;
            if (TMO_ERR !== 1'b0) tmo_hi++;
        end
        chk("withdraw.dmr_profile", mism, 0);
        chk("withdraw.dmg", dmg_low, 0);
        chk("withdraw.busy", busy_hi, 0);
        chk("withdraw.tmo_err", tmo_hi, 0);
        $display("session withdraw: dmr_mismatch_cycles=%0d dmg_cycles=%0d", mism, dmg_low);
        run_session(model_session(2'b01, 2, 3, 2, 1'b0), "after_withdraw");

        // Reset while requester 1 owns the bus.
        nREQ_DMR[1] = 1'b0;
        wait_for(0, cyc);
        nCPU_DMGO = 1'b0;
        wait_for(1, cyc);
        chk("rst.dmg_lat", cyc, LAT);
        repeat (2) @(negedge CLK);
        nREQ_SACK[1] = 1'b0;
        wait_for(2, cyc);
        repeat (2) @(negedge CLK);
        chk("rst.pre_sack", int'(nCPU_SACK), 0);
        chk("rst.pre_owner", int'(OWNER), 1);
        chk("rst.pre_busy", int'(BUSY), 1);
        @(posedge CLK);
        #2 nRESET = 1'b0;
        #1;
        chk("rst.sack", int'(nCPU_SACK), 1);
        chk("rst.dmr", int'(nCPU_DMR), 1);
        chk("rst.dmg", int'(nREQ_DMG), (1 << NREQ) - 1);
        chk("rst.busy", int'(BUSY), 0);
        chk("rst.owner", int'(OWNER), 0);
        $display("session reset_in_own: sack=%b dmr=%b dmg=%b busy=%b", nCPU_SACK, nCPU_DMR,
                 nREQ_DMG, BUSY);
        nREQ_DMR = '1; nREQ_SACK = '1; nCPU_DMGO = 1'b1;
        @(negedge CLK);
        nRESET = 1'b1;
        m_ptr = 0;
        repeat (2) @(negedge CLK);
        run_session(model_session(2'b10, 3, 2, 4, 1'b0), "after_reset");

        // Randomized sessions against the reference model.
        for (int n = 0; n < 30; n++) begin
            logic [NREQ-1:0] mask;
            int d;
            mask = NREQ'($urandom_range(1, (1 << NREQ) - 1));
            d = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 18));
            v = model_session(mask, int'($urandom_range(1, 8)), d,
                              int'($urandom_range(1, 10)), bit'($urandom_range(0, 1)));
            run_session(v, $sformatf("rand%0d", n));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
